// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and policy constants for the bus arbiters
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT   = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - masked priority encoder: first request at or above ptr, else lowest overall
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             mode,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [ID_W-1:0]  idx_masked;
    logic [ID_W-1:0]  idx_all;

    always_comb begin
        mask       = '0;
        idx_masked = '0;
        idx_all    = '0;
        // Fixed-priority mode opens the mask fully, so the first pass alone decides.
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (mode != 1'(ARB_RR)) || (i >= int'(ptr));
        end
        masked = req & mask;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (masked[i]) idx_masked = ID_W'(i);
            if (req[i])    idx_all    = ID_W'(i);
        end
        found  = |req;
        winner = (|masked) ? idx_masked : idx_all;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - N-requester RQ/GRANT bus arbiter with release turnaround and hold watchdog
module bus_arbiter_rr
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] bus_rq,
    input  logic             bus_mem_ready,
    output logic [N_REQ-1:0] bus_grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             hold_timeout,
    output logic             busy
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [ID_W-1:0]  win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic             timeout_next;

    arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (bus_rq),
        .ptr    (ptr),
        .mode   (RR_MODE == ARB_RR),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_next   = state;
        hold_next    = '0;
        timeout_next = 1'b0;

        case (state)
            ARB_IDLE:    if (pick_found && !bus_mem_ready) state_next = ARB_GRANT;
            ARB_GRANT:   if (!bus_rq[grant_id])            state_next = ARB_RELEASE;
            ARB_RELEASE: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase

        win_idx    = (state == ARB_IDLE) ? pick_idx : grant_id;
        win_onehot = N_REQ'(1) << win_idx;

        // Counter holds the number of grant cycles including the one about to start.
        if (state_next == ARB_GRANT) begin
            hold_next = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
        end

        timeout_next = (MAX_HOLD != 0) && (state_next == ARB_GRANT) &&
                       (hold_next == HOLD_W'(MAX_HOLD)) && (hold_cnt != HOLD_W'(MAX_HOLD)) &&
                       (|(bus_rq & ~win_onehot));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            bus_grant    <= '0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            hold_timeout <= 1'b0;
            busy         <= 1'b0;
            ptr          <= '0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            hold_timeout <= timeout_next;
            busy         <= (state_next != ARB_IDLE);
            grant_valid  <= (state_next == ARB_GRANT);
            bus_grant    <= (state_next == ARB_GRANT) ? win_onehot : '0;
            if (state == ARB_IDLE && state_next == ARB_GRANT) begin
                grant_id <= pick_idx;
                if (RR_MODE == ARB_RR) begin
                    ptr <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised N-requester bus arbiter for the shared instruction or data bus. It serves the RQ/GRANT handshake that each core's arbitration submodule drives, with one instance per bus. It generalises the single-requester pseudo arbiter to N cores, with selectable fixed-priority or round-robin policy, a release/turnaround phase, a memory-ready interlock, and a hold-time watchdog.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), width of grant_id
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
MAX_HOLD, 64, cycles a grant may be held before hold_timeout pulses (0 disables the watchdog)
HOLD_W, 8, width of the hold counter; must satisfy MAX_HOLD < 2**HOLD_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
bus_rq  in  N_REQ  per-core bus request (D_Bus_RQ / I_Bus_RQ from each submodule)
bus_mem_ready  in  1  memory ready on the shared bus
bus_grant  out  N_REQ  one-hot grant to each submodule
grant_valid  out  1  high while any grant is asserted
grant_id  out  ID_W  index of the current grantee; holds its last value when idle
hold_timeout  out  1  one-cycle pulse when a grant reaches MAX_HOLD cycles while another request is pending
busy  out  1  high in GRANT and RELEASE states

Behaviour:
- Reset (reset=0, async): state=IDLE, bus_grant=0, grant_valid=0, grant_id=0, hold_timeout=0, busy=0, rr pointer=0, hold counter=0.
- All outputs are registered. No combinational path from bus_rq to bus_grant.
- FSM states:
  - IDLE -> GRANT when |bus_rq && !bus_mem_ready. The winner is latched and bus_grant asserts on the next edge (1-cycle request-to-grant latency). If bus_mem_ready=1, stay in IDLE (wait for memory to go low).
  - GRANT: bus_grant[winner] stays high while bus_rq[winner]=1. Other requests are ignored; a grant is never revoked. GRANT -> RELEASE when bus_rq[winner]=0; bus_grant drops on that same edge.
  - RELEASE: exactly one turnaround cycle with bus_grant=0, so the submodule can tri-state its bus outputs. RELEASE -> IDLE unconditionally.
- Minimum gap between two grants is 2 cycles (RELEASE + IDLE evaluation). A back-to-back requester never sees grant in consecutive cycles.
- Winner selection:
  - RR_MODE=1: first set bit searching upward from pointer, wrapping from N_REQ-1 to 0. On entering GRANT, the pointer becomes (winner+1) mod N_REQ.
  - RR_MODE=0: lowest set index wins; the pointer is unused.
- Hold counter:
  - Cleared on entering GRANT; increments each GRANT cycle and saturates at 2**HOLD_W-1.
  - hold_timeout pulses for one cycle when the counter equals MAX_HOLD and any other bit of bus_rq is set.
  - Advisory only; it does not alter the grant.
- Edge cases:
  - Requester deasserts bus_rq before its grant arrives (dropped in the IDLE->GRANT cycle): the grant still asserts for one cycle, then GRANT -> RELEASE.
  - All requests drop simultaneously: the current grantee follows normal release; there is no spurious grant.
  - bus_mem_ready high in GRANT: ignored; it is only checked in IDLE.
  - reset asserted mid-GRANT: bus_grant clears immediately (asynchronously).
  - N_REQ not a power of two: pointer wrap uses modulo N_REQ, not 2**ID_W.

Decomposition:
- Shared package arb_pkg: state encoding localparams (ARB_IDLE=2'b00, ARB_GRANT=2'b01, ARB_RELEASE=2'b10), and the policy constants ARB_FIXED=0, ARB_RR=1.
- One sub-module, arb_rr_pick: combinational masked priority encoder. Inputs: req, ptr, mode. Outputs: winner index and a found flag. Its two-pass mask/unmask structure is reused by the future data/instruction dual-bus arbiter.

Test Plan (N_REQ=4, RR_MODE=1, MAX_HOLD=8 unless noted):
- Single request: bus_rq=4'b0100 with mem_ready=0 -> bus_grant=4'b0100 one cycle later, grant_id=2. Drop rq -> grant low on the same edge; next grant no earlier than 2 cycles later.
- Round-robin fairness: hold bus_rq=4'b1111, each grantee drops rq after 3 cycles -> grant order 0,1,2,3,0. Verify wrap from 3 to 0.
- Fixed priority (RR_MODE=0): bus_rq=4'b1010 repeated -> core 1 always wins; core 3 granted only when bus_rq=4'b1000.
- Memory interlock: bus_rq=4'b0001 with mem_ready=1 for 5 cycles -> no grant. Drop mem_ready -> grant_id=0 on the next edge.
- Watchdog: core 0 holds grant 12 cycles while bus_rq[2]=1 -> hold_timeout pulses once at grant cycle 8; grant remains with core 0. With MAX_HOLD=0 -> no pulse.
- Reset mid-grant: reset=0 during core 1's grant -> bus_grant=0 before the next clk edge. After release, pointer=0 and bus_rq=4'b0110 -> core 1 is granted first.
